// File: rtl/tdc_channel_fifo.sv
// TDC channel: measures discriminator pulses (start time + time over threshold)
// and queues them in a show-ahead event FIFO with a sticky overflow flag.
package tdc_channel_fifo_pkg;
    typedef enum logic [2:0] {
        CHAN_0 = 3'd0, CHAN_1 = 3'd1, CHAN_2 = 3'd2, CHAN_3 = 3'd3,
        CHAN_4 = 3'd4, CHAN_5 = 3'd5, CHAN_6 = 3'd6, CHAN_7 = 3'd7
    } TDC_CHANNEL;
endpackage

module tdc_channel_fifo
    import tdc_channel_fifo_pkg::*;
#(
    parameter TDC_CHANNEL CHANNEL    = CHAN_0,
    parameter int         TS_WIDTH   = 32,
    parameter int         TOT_WIDTH  = 32,
    parameter int         FIFO_DEPTH = 8,
    parameter int         MIN_TOT    = 1
) (
    input  logic                        clk,
    input  logic                        clear,
    input  logic                        trigger,
    input  logic                        enable,
    input  logic                        rd_en,
    output logic                        hasEvent,
    output logic [TS_WIDTH-1:0]         timestamp,
    output logic [TOT_WIDTH-1:0]        timeOverThreshold,
    output TDC_CHANNEL                  chan,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fill
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]        DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [TOT_WIDTH-1:0] MIN_TOT_C = TOT_WIDTH'(MIN_TOT);
    localparam logic [TOT_WIDTH-1:0] TOT_MAX_C = {TOT_WIDTH{1'b1}};

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    logic [TS_WIDTH-1:0]  tb_r;
    logic                 trig_d_r;
    logic [0:0]           state_r;
    logic [TS_WIDTH-1:0]  start_ts_r;
    logic [TOT_WIDTH-1:0] tot_cnt_r;

    logic [TS_WIDTH-1:0]  mem_ts_r  [FIFO_DEPTH];
    logic [TOT_WIDTH-1:0] mem_tot_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;
    logic                 overflow_r;
    logic                 has_event_r;
    logic [TS_WIDTH-1:0]  head_ts_r;
    logic [TOT_WIDTH-1:0] head_tot_r;

    logic                 rise_s;
    logic                 fall_s;
    logic                 push_req_s;
    logic                 pop_s;
    logic                 push_do_s;
    logic [CW-1:0]        next_count_s;
    logic [AW-1:0]        next_rd_s;
    logic [TS_WIDTH-1:0]  next_head_ts_s;
    logic [TOT_WIDTH-1:0] next_head_tot_s;

    assign rise_s     = trigger & ~trig_d_r;
    assign fall_s     = ~trigger & trig_d_r;
    assign push_req_s = ~clear & (state_r == ST_MEASURE) & fall_s & (tot_cnt_r >= MIN_TOT_C);
    assign pop_s      = ~clear & rd_en & (count_r != {CW{1'b0}});
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_do_s  = push_req_s & ((count_r != DEPTH_C) | pop_s);

    // Time base and trigger history; trig_d resets high so a pulse spanning clear is ignored.
    always_ff @(posedge clk) begin
        if (clear) begin
            tb_r     <= {TS_WIDTH{1'b0}};
            trig_d_r <= 1'b1;
        end else begin
            trig_d_r <= trigger;
            if (enable) begin
                tb_r <= tb_r + {{(TS_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Pulse measurement FSM; enable only gates the start of a pulse, never its end.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r    <= ST_IDLE;
            start_ts_r <= {TS_WIDTH{1'b0}};
            tot_cnt_r  <= {TOT_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rise_s && enable) begin
                        state_r    <= ST_MEASURE;
                        start_ts_r <= tb_r;
                        tot_cnt_r  <= {{(TOT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_MEASURE: begin
                    if (fall_s) begin
                        state_r <= ST_IDLE;
                    end else if (trigger && (tot_cnt_r != TOT_MAX_C)) begin
                        tot_cnt_r <= tot_cnt_r + {{(TOT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Next occupancy and next head entry, so the show-ahead outputs can be registered.
    always_comb begin
        next_count_s    = count_r;
        next_rd_s       = rd_ptr_r;
        next_head_ts_s  = {TS_WIDTH{1'b0}};
        next_head_tot_s = {TOT_WIDTH{1'b0}};
        case ({push_do_s, pop_s})
            2'b10:   next_count_s = count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   next_count_s = count_r - {{(CW-1){1'b0}}, 1'b1};
            default: next_count_s = count_r;
        endcase
        if (pop_s) begin
            next_rd_s = rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            next_rd_s = rd_ptr_r;
        end
        // The new head may be the entry being written this very cycle.
        if (next_count_s == {CW{1'b0}}) begin
            next_head_ts_s  = {TS_WIDTH{1'b0}};
            next_head_tot_s = {TOT_WIDTH{1'b0}};
        end else if (push_do_s && (next_rd_s == wr_ptr_r)) begin
            next_head_ts_s  = start_ts_r;
            next_head_tot_s = tot_cnt_r;
        end else begin
            next_head_ts_s  = mem_ts_r[next_rd_s];
            next_head_tot_s = mem_tot_r[next_rd_s];
        end
    end

    // Event storage; contents need no reset since occupancy governs validity.
    always_ff @(posedge clk) begin
        if (push_do_s) begin
            mem_ts_r[wr_ptr_r]  <= start_ts_r;
            mem_tot_r[wr_ptr_r] <= tot_cnt_r;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and registered head outputs.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            overflow_r  <= 1'b0;
            has_event_r <= 1'b0;
            head_ts_r   <= {TS_WIDTH{1'b0}};
            head_tot_r  <= {TOT_WIDTH{1'b0}};
        end else begin
            if (push_do_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (push_req_s && !push_do_s) begin
                overflow_r <= 1'b1;
            end
            rd_ptr_r    <= next_rd_s;
            count_r     <= next_count_s;
            has_event_r <= (next_count_s != {CW{1'b0}});
            head_ts_r   <= next_head_ts_s;
            head_tot_r  <= next_head_tot_s;
        end
    end

    assign hasEvent          = has_event_r;
    assign timestamp         = head_ts_r;
    assign timeOverThreshold = head_tot_r;
    assign chan              = CHANNEL;
    assign overflow          = overflow_r;
    assign fill              = count_r;

endmodule

// File: tb/tb_tdc_channel_fifo.sv
// Bench for tdc_channel_fifo: a default instance and a small (8-bit, depth 4,
// MIN_TOT 3) instance share stimulus and are compared against a pulse/queue model.
module tb_tdc_channel_fifo;
    import tdc_channel_fifo_pkg::*;

    logic clk = 1'b0;
    logic clear_s = 1'b1, trigger_s = 1'b0, enable_s = 1'b1, rd_en_s = 1'b0;

    logic        d_has_s, d_ovf_s;
    logic [31:0] d_ts_s, d_tot_s;
    logic [3:0]  d_fill_s;
    TDC_CHANNEL  d_chan_s;
    logic        s_has_s, s_ovf_s;
    logic [7:0]  s_ts_s, s_tot_s;
    logic [2:0]  s_fill_s;
    TDC_CHANNEL  s_chan_s;

    int total = 0;
    int bad   = 0;

    // reference model state, index 0 = default instance, 1 = small instance
    longint c_mod[2], c_max[2];
    int     c_depth[2], c_min[2];
    longint m_tb[2], m_start[2], m_len[2];
    bit     m_prev[2], m_act[2], m_ovf[2];
    int     m_cnt[2];
    longint m_fts[2][8], m_ftot[2][8];

    always #5 clk = ~clk;

    tdc_channel_fifo u_dut (
        .clk(clk), .clear(clear_s), .trigger(trigger_s), .enable(enable_s), .rd_en(rd_en_s),
        .hasEvent(d_has_s), .timestamp(d_ts_s), .timeOverThreshold(d_tot_s),
        .chan(d_chan_s), .overflow(d_ovf_s), .fill(d_fill_s)
    );

    tdc_channel_fifo #(
        .CHANNEL(CHAN_5), .TS_WIDTH(8), .TOT_WIDTH(8), .FIFO_DEPTH(4), .MIN_TOT(3)
    ) u_small (
        .clk(clk), .clear(clear_s), .trigger(trigger_s), .enable(enable_s), .rd_en(rd_en_s),
        .hasEvent(s_has_s), .timestamp(s_ts_s), .timeOverThreshold(s_tot_s),
        .chan(s_chan_s), .overflow(s_ovf_s), .fill(s_fill_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock edge of the behavioural model: pulses become {start, width} records in a list
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (clear_s) begin
                m_tb[i] = 0; m_prev[i] = 1'b1; m_act[i] = 1'b0; m_len[i] = 0;
                m_cnt[i] = 0; m_ovf[i] = 1'b0;
            end else begin
                bit     pushing = 1'b0;
                longint p_ts = 0, p_tot = 0;
                if (m_act[i]) begin
                    if (trigger_s) begin
                        m_len[i] = (m_len[i] + 1 > c_max[i]) ? c_max[i] : m_len[i] + 1;
                    end else begin
                        m_act[i] = 1'b0;
                        if (m_len[i] >= c_min[i]) begin
                            pushing = 1'b1; p_ts = m_start[i]; p_tot = m_len[i];
                        end
                    end
                end else if (trigger_s && !m_prev[i] && enable_s) begin
                    m_act[i] = 1'b1; m_start[i] = m_tb[i]; m_len[i] = 1;
                end
                if (rd_en_s && m_cnt[i] > 0) begin
                    for (int k = 0; k < 7; k++) begin
                        m_fts[i][k] = m_fts[i][k+1];
                        m_ftot[i][k] = m_ftot[i][k+1];
                    end
                    m_cnt[i] = m_cnt[i] - 1;
                end
                if (pushing) begin
                    if (m_cnt[i] < c_depth[i]) begin
                        m_fts[i][m_cnt[i]] = p_ts;
                        m_ftot[i][m_cnt[i]] = p_tot;
                        m_cnt[i] = m_cnt[i] + 1;
                    end else begin
                        m_ovf[i] = 1'b1;
                    end
                end
                m_prev[i] = trigger_s;
                if (enable_s) m_tb[i] = (m_tb[i] + 1) % c_mod[i];
            end
        end
    endtask

    task automatic compare_all();
        check("d.has",  64'(d_has_s),  64'(m_cnt[0] > 0));
        check("d.ts",   64'(d_ts_s),   64'((m_cnt[0] > 0) ? m_fts[0][0] : 0));
        check("d.tot",  64'(d_tot_s),  64'((m_cnt[0] > 0) ? m_ftot[0][0] : 0));
        check("d.fill", 64'(d_fill_s), 64'(m_cnt[0]));
        check("d.ovf",  64'(d_ovf_s),  64'(m_ovf[0]));
        check("d.chan", 64'(d_chan_s), 64'(CHAN_0));
        check("s.has",  64'(s_has_s),  64'(m_cnt[1] > 0));
        check("s.ts",   64'(s_ts_s),   64'((m_cnt[1] > 0) ? m_fts[1][0] : 0));
        check("s.tot",  64'(s_tot_s),  64'((m_cnt[1] > 0) ? m_ftot[1][0] : 0));
        check("s.fill", 64'(s_fill_s), 64'(m_cnt[1]));
        check("s.ovf",  64'(s_ovf_s),  64'(m_ovf[1]));
        check("s.chan", 64'(s_chan_s), 64'(CHAN_5));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse(input int hi, input int lo, input bit rd_on_fall);
        trigger_s = 1'b1;
        repeat (hi) step();
        trigger_s = 1'b0;
        rd_en_s = rd_on_fall;
        step();
        rd_en_s = 1'b0;
        repeat (lo - 1) step();
    endtask

    task automatic do_clear();
        clear_s = 1'b1;
        step();
        clear_s = 1'b0;
    endtask

    initial begin
        c_mod[0] = 64'h1_0000_0000; c_max[0] = 64'hFFFF_FFFF; c_depth[0] = 8; c_min[0] = 1;
        c_mod[1] = 256;             c_max[1] = 255;           c_depth[1] = 4; c_min[1] = 3;
        for (int i = 0; i < 2; i++) begin
            m_tb[i] = 0; m_prev[i] = 1'b1; m_act[i] = 1'b0; m_len[i] = 0; m_start[i] = 0;
            m_cnt[i] = 0; m_ovf[i] = 1'b0;
        end

        // reset with trigger already high, then release: that pulse must be ignored
        clear_s = 1'b1; trigger_s = 1'b1;
        repeat (3) step();
        check("rst.d.fill", 64'(d_fill_s), 64'd0);
        check("rst.s.ts",   64'(s_ts_s),   64'd0);
        clear_s = 1'b0;
        repeat (4) step();
        trigger_s = 1'b0;
        repeat (2) step();
        check("span.d.has", 64'(d_has_s), 64'd0);
        check("span.s.has", 64'(s_has_s), 64'd0);

        // pulse high on cycles 10..14 after release
        do_clear();
        repeat (10) step();
        trigger_s = 1'b1;
        repeat (5) step();
        check("p37.pre.has", 64'(d_has_s), 64'd0);
        trigger_s = 1'b0;
        step();
        check("p37.has", 64'(d_has_s), 64'd1);
        check("p37.ts",  64'(d_ts_s),  64'd10);
        check("p37.tot", 64'(d_tot_s), 64'd5);
        rd_en_s = 1'b1; step(); rd_en_s = 1'b0;
        check("p37.pop", 64'(d_has_s), 64'd0);

        // MIN_TOT filtering and back-to-back pulses
        do_clear();
        step();
        pulse(2, 1, 1'b0);
        pulse(3, 2, 1'b0);
        check("min.s.fill", 64'(s_fill_s), 64'd1);
        check("min.s.tot",  64'(s_tot_s),  64'd3);
        check("min.d.fill", 64'(d_fill_s), 64'd2);

        // fill the small FIFO, push+pop while full, then overflow
        do_clear();
        step();
        repeat (4) pulse(3, 2, 1'b0);
        check("full.s.fill", 64'(s_fill_s), 64'd4);
        check("full.s.ovf",  64'(s_ovf_s),  64'd0);
        pulse(3, 2, 1'b1);
        check("pp.s.fill", 64'(s_fill_s), 64'd4);
        check("pp.s.ovf",  64'(s_ovf_s),  64'd0);
        pulse(3, 2, 1'b0);
        check("ovf.s.fill", 64'(s_fill_s), 64'd4);
        check("ovf.s.ovf",  64'(s_ovf_s),  64'd1);
        rd_en_s = 1'b1;
        repeat (7) step();
        rd_en_s = 1'b0;
        check("drain.s.ovf", 64'(s_ovf_s), 64'd1);

        // 8-bit time base wrap: start at 255, next pulse starts at 0
        do_clear();
        repeat (255) step();
        trigger_s = 1'b1; step();
        enable_s = 1'b0; step(); step();
        trigger_s = 1'b0; step();
        trigger_s = 1'b1; enable_s = 1'b1; step(); step(); step();
        trigger_s = 1'b0; step();
        check("wrap.s.fill", 64'(s_fill_s), 64'd2);
        check("wrap.s.ts0",  64'(s_ts_s),   64'd255);
        check("wrap.d.ts0",  64'(d_ts_s),   64'd255);
        rd_en_s = 1'b1; step(); rd_en_s = 1'b0;
        check("wrap.s.ts1",  64'(s_ts_s),   64'd0);
        check("wrap.s.tot1", 64'(s_tot_s),  64'd3);

        // clear in the middle of a pulse aborts it
        do_clear();
        step();
        trigger_s = 1'b1;
        repeat (3) step();
        do_clear();
        repeat (2) step();
        trigger_s = 1'b0;
        repeat (3) step();
        check("abort.d.has", 64'(d_has_s), 64'd0);
        check("abort.d.ts",  64'(d_ts_s),  64'd0);
        check("abort.d.tot", 64'(d_tot_s), 64'd0);
        check("abort.s.ovf", 64'(s_ovf_s), 64'd0);

        // randomized traffic against the model
        repeat (800) begin
            clear_s   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) == 0) trigger_s = ~trigger_s;
            enable_s  = ($urandom_range(0, 9) != 0);
            rd_en_s   = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
